zmod_rxdll_align: RTL and testbench
===================================

# zmod_rxdll_align

Training controller for the ZMOD receive-clock MMCM. It resets the MMCM and waits for lock, then sweeps the MMCM fine phase shift across one full RX clock period while checking a known training word on every lane. It then moves the clock to the centre of the widest passing window. It sits between the RX clock MMCM wrapper (PSEN/PSINCDEC/PSDONE, RST, LOCKED) and the per-lane deserialisers, all in the divided RX clock domain.

## Interface
- NLANES, 2: number of data lanes checked in parallel
- WORD_W, 8: deserialised word width per lane
- PATTERN, 8'hA5: expected training word (WORD_W bits), identical on all lanes
- PS_RANGE, 112: fine phase steps per RX clock period (360°)
- SAMPLE_CNT, 256: words compared per phase position
- MIN_EYE, 8: minimum passing-run width for success
- RST_CYCLES, 16: MMCM reset pulse length
- LOCK_TIMEOUT, 65535: cycles allowed for LOCKED, and separately for each PSDONE
- clk  in  1  divided RX clock; all logic is on this edge
- resetn  in  1  synchronous reset, active low
- start  in  1  one-cycle pulse to begin training; ignored while busy
- rx_data  in  NLANES*WORD_W  deserialised words; lane i is bits [i*WORD_W +: WORD_W]
- mmcm_locked  in  1  MMCM LOCKED, already synchronised to clk
- ps_done  in  1  MMCM PSDONE, one-cycle pulse
- mmcm_rst  out  1  MMCM RST
- ps_en  out  1  MMCM PSEN, one-cycle pulse
- ps_incdec  out  1  MMCM PSINCDEC, tied to 1 (increment only)
- busy  out  1  training in progress
- done  out  1  trained; held until the next start, reset, or lock loss
- fail  out  1  training failed; held until the next start or reset
- eye_start  out  $clog2(PS_RANGE)  first passing step of the chosen window
- eye_width  out  $clog2(PS_RANGE)+1  width of the chosen window in steps

## Operation
- States: IDLE, MRST, WLOCK, SAMPLE, STEP, CENTER, DONE, FAIL.
- IDLE -> MRST on start. The same transition occurs from DONE or FAIL on start.
- MRST: mmcm_rst=1 for RST_CYCLES cycles. Clears the position counter, the best run and the current run. Then goes to WLOCK.
- WLOCK: waits for mmcm_locked=1, then goes to SAMPLE. A timeout goes to FAIL.
- SAMPLE: compares SAMPLE_CNT consecutive words on all lanes against PATTERN. Any mismatch on any lane marks the position as bad.
- A good position extends the current run. A bad position ends it. When a run ends, it replaces the best run if it is strictly longer (first-found wins ties).
- SAMPLE -> STEP. STEP issues one ps_en pulse, waits for ps_done, and increments the position.
- If position < PS_RANGE after the step, return to SAMPLE. Otherwise close any open run; windows do not wrap across position 0.
- At sweep end, a best width < MIN_EYE goes to FAIL. Otherwise go to CENTER, latch eye_start and eye_width, and set the target to eye_start + eye_width/2 (floor).
- The phase is now back at 0°. CENTER issues target ps_en/ps_done pairs, then goes to DONE.
- A ps_done timeout, in either STEP or CENTER, goes to FAIL.
- DONE: done=1. If mmcm_locked falls, clear done and go to MRST (automatic retrain).
- mmcm_locked falling during SAMPLE, STEP or CENTER also restarts at MRST.

## Timing
- Reset values: mmcm_rst=1, ps_en=0, ps_incdec=1, busy=0, done=0, fail=0, eye_start=0, eye_width=0. The FSM is in IDLE.
- mmcm_rst stays 1 for the whole time resetn=0. A reset mid-training abandons training.
- The MMCM is held in reset while in IDLE and FAIL.
- ps_en is high exactly one cycle per step. No new ps_en is issued before ps_done for the previous step.
- rx_data is registered before comparison, giving 1 cycle of compare latency.
- The first 4 words after each ps_done or lock are discarded before counting SAMPLE_CNT.
- busy=1 in every state except IDLE, DONE and FAIL.
- done/fail rise one cycle after the final transition.
- eye_start and eye_width update only on the transition into CENTER.
- A start pulse that coincides with a lock loss in DONE is treated as a single retrain.

## Structure
- Package zmod_pkg: the state enum (align_state_t), lane word typedef, and the count of discarded words.
- Sub-module zmod_rx_patchk: per-window pattern checker holding the word counter, the discard counter and the sticky per-lane error. It outputs win_done and win_err; NLANES is a parameter.
- The run/best tracking and the FSM live in the top module.

## Test plan
- **Full pass window:** MMCM model passes only at positions 40..71 -> done=1, eye_start=40, eye_width=32; 40+16=56 ps_en pulses in CENTER.
- **Narrow eye:** passes only at 10..14 with MIN_EYE=8 -> fail=1, done=0, mmcm_rst=1.
- **Tie between windows:** two windows 20..29 and 60..69 -> eye_start=20, eye_width=10.
- **Lane-1-only error:** lane 1 errors at 50 while lane 0 is clean over 30..80 -> window 51..80, eye_start=51, eye_width=30.
- **Lock loss after done:** mmcm_locked dropped after done -> done=0, mmcm_rst high for 16 cycles, retrain completes with the same result.
- **Timeouts and mid-training reset:** ps_done withheld -> fail after 65535 cycles. resetn=0 during SAMPLE -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/zmod_pkg.sv
// Shared types and constants for the ZMOD RX clock alignment controller.
package zmod_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MRST,
      S_WLOCK,
      S_SAMPLE,
      S_STEP,
      S_CENTER,
      S_DONE,
      S_FAIL
   } align_state_t;

   typedef logic [7:0] lane_word_t;

   // Words dropped after every phase move or lock while the deserialisers settle.
   localparam int unsigned DISCARD_WORDS = 4;
   localparam int unsigned DISC_W        = $clog2(DISCARD_WORDS + 1);

endpackage

// File: rtl/zmod_rx_patchk.sv
// Per-window training-word checker: skips the settling words after a phase
// move, then compares SAMPLE_CNT words on every lane with a sticky error.
module zmod_rx_patchk
   import zmod_pkg::*;
#(
   parameter int unsigned       NLANES     = 2,
   parameter int unsigned       WORD_W     = $bits(lane_word_t),
   parameter logic [WORD_W-1:0] PATTERN    = 8'hA5,
   parameter int unsigned       SAMPLE_CNT = 256
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     win_start,
   input  logic [NLANES*WORD_W-1:0] rx_data,
   output logic                     win_done,
   output logic                     win_err
);

   localparam int unsigned       CNT_W     = $clog2(SAMPLE_CNT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SAMPLE_CNT - 1);
   localparam logic [DISC_W-1:0] DISC_LAST = DISC_W'(DISCARD_WORDS);

   logic [NLANES*WORD_W-1:0] rx_q;
   logic [NLANES-1:0]        lane_bad;
   logic [NLANES-1:0]        lane_err;
   logic                     active;
   logic [DISC_W-1:0]        disc_cnt;
   logic [CNT_W-1:0]         word_cnt;

   // NOTE: rx_q is a pure pipeline stage whose contents are ignored until a
   // window has discarded its settling words, so it needs no reset.
   always_ff @(posedge clk) rx_q <= rx_data;

   // NOTE: lane_bad gets a default before the loop so every path assigns it
   // and no latch is inferred.
   always_comb begin
      lane_bad = '0;
      for (int i = 0; i < NLANES; i++)
         lane_bad[i] = (rx_q[i*WORD_W +: WORD_W] != PATTERN);
   end

   // NOTE: state is updated with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         active   <= 1'b0;
         disc_cnt <= '0;
         word_cnt <= '0;
         lane_err <= '0;
         win_done <= 1'b0;
      end else begin
         win_done <= 1'b0;
         if (win_start) begin
            active   <= 1'b1;
            disc_cnt <= '0;
            word_cnt <= '0;
            lane_err <= '0;
         end else if (active) begin
            if (disc_cnt != DISC_LAST) begin
               disc_cnt <= disc_cnt + 1'b1;
            end else begin
               lane_err <= lane_err | lane_bad;
               word_cnt <= word_cnt + 1'b1;
               if (word_cnt == CNT_LAST) begin
                  active   <= 1'b0;
                  win_done <= 1'b1;
               end
            end
         end
      end
   end

   assign win_err = |lane_err;

endmodule

// File: rtl/zmod_rxdll_align.sv
// ZMOD RX clock training controller: resets the MMCM, sweeps its fine phase
// over one RX period, and parks it in the centre of the widest passing window.
module zmod_rxdll_align
   import zmod_pkg::*;
#(
   parameter int unsigned       NLANES       = 2,
   parameter int unsigned       WORD_W       = $bits(lane_word_t),
   parameter logic [WORD_W-1:0] PATTERN      = 8'hA5,
   parameter int unsigned       PS_RANGE     = 112,
   parameter int unsigned       SAMPLE_CNT   = 256,
   parameter int unsigned       MIN_EYE      = 8,
   parameter int unsigned       RST_CYCLES   = 16,
   parameter int unsigned       LOCK_TIMEOUT = 65535
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          start,
   input  logic [NLANES*WORD_W-1:0]      rx_data,
   input  logic                          mmcm_locked,
   input  logic                          ps_done,
   output logic                          mmcm_rst,
   output logic                          ps_en,
   output logic                          ps_incdec,
   output logic                          busy,
   output logic                          done,
   output logic                          fail,
   output logic [$clog2(PS_RANGE)-1:0]   eye_start,
   output logic [$clog2(PS_RANGE):0]     eye_width
);

   localparam int unsigned ES_W    = $clog2(PS_RANGE);
   localparam int unsigned EW_W    = ES_W + 1;
   localparam int unsigned SUM_W   = EW_W + 1;
   localparam int unsigned POS_W   = $clog2(PS_RANGE + 1);
   localparam int unsigned TMR_MAX = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(LOCK_TIMEOUT - 1);
   localparam logic [POS_W-1:0] PS_LAST  = POS_W'(PS_RANGE - 1);
   localparam logic [EW_W-1:0]  EYE_MIN  = EW_W'(MIN_EYE);

   align_state_t     state;
   logic [TMR_W-1:0] timer;
   logic [POS_W-1:0] pos;
   logic [POS_W-1:0] target;
   logic             ps_wait;
   logic             win_start;
   logic             win_done;
   logic             win_err;
   logic [ES_W-1:0]  cur_start;
   logic [ES_W-1:0]  best_start;
   logic [ES_W-1:0]  fin_start;
   logic [EW_W-1:0]  cur_len;
   logic [EW_W-1:0]  best_len;
   logic [EW_W-1:0]  fin_len;
   logic [SUM_W-1:0] tgt_sum;

   assign ps_incdec = 1'b1;

   zmod_rx_patchk #(
      .NLANES     (NLANES),
      .WORD_W     (WORD_W),
      .PATTERN    (PATTERN),
      .SAMPLE_CNT (SAMPLE_CNT)
   ) u_patchk (
      .clk       (clk),
      .resetn    (resetn),
      .win_start (win_start),
      .rx_data   (rx_data),
      .win_done  (win_done),
      .win_err   (win_err)
   );

   // Best run after closing the current one; a tie keeps the earlier window.
   always_comb begin
      fin_start = best_start;
      fin_len   = best_len;
      if (cur_len > best_len) begin
         fin_start = cur_start;
         fin_len   = cur_len;
      end
      tgt_sum = SUM_W'(fin_start) + SUM_W'(fin_len >> 1);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= S_IDLE;
         timer      <= '0;
         pos        <= '0;
         target     <= '0;
         ps_wait    <= 1'b0;
         win_start  <= 1'b0;
         cur_start  <= '0;
         cur_len    <= '0;
         best_start <= '0;
         best_len   <= '0;
         mmcm_rst   <= 1'b1;
         ps_en      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fail       <= 1'b0;
         eye_start  <= '0;
         eye_width  <= '0;
      end else begin
         ps_en     <= 1'b0;
         win_start <= 1'b0;
         case (state)
            S_IDLE, S_FAIL: begin
               if (start) begin
                  state <= S_MRST;
                  timer <= '0;
                  busy  <= 1'b1;
                  fail  <= 1'b0;
               end
            end

            // A start coinciding with lock loss still yields one retrain.
            S_DONE: begin
               if (start || !mmcm_locked) begin
                  state    <= S_MRST;
                  timer    <= '0;
                  mmcm_rst <= 1'b1;
                  busy     <= 1'b1;
                  done     <= 1'b0;
               end
            end

            S_MRST: begin
               pos        <= '0;
               ps_wait    <= 1'b0;
               cur_start  <= '0;
               cur_len    <= '0;
               best_start <= '0;
               best_len   <= '0;
               if (timer == RST_LAST) begin
                  state    <= S_WLOCK;
                  timer    <= '0;
                  mmcm_rst <= 1'b0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            S_WLOCK: begin
               if (mmcm_locked) begin
                  state     <= S_SAMPLE;
                  win_start <= 1'b1;
               end else if (timer == TMO_LAST) begin
                  state    <= S_FAIL;
                  mmcm_rst <= 1'b1;
                  busy     <= 1'b0;
                  fail     <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            // win_done is ignored on the first cycle so a stale window never counts.
            S_SAMPLE: begin
               if (!mmcm_locked) begin
                  state    <= S_MRST;
                  timer    <= '0;
                  mmcm_rst <= 1'b1;
               end else if (win_done && !win_start) begin
                  if (win_err) begin
                     best_start <= fin_start;
                     best_len   <= fin_len;
                     cur_len    <= '0;
                  end else begin
                     if (cur_len == '0) cur_start <= ES_W'(pos);
                     cur_len <= cur_len + 1'b1;
                  end
                  ps_en <= 1'b1;
                  timer <= '0;
                  state <= S_STEP;
               end
            end

            S_STEP: begin
               if (!mmcm_locked) begin
                  state    <= S_MRST;
                  timer    <= '0;
                  mmcm_rst <= 1'b1;
               end else if (ps_done) begin
                  if (pos != PS_LAST) begin
                     pos       <= pos + 1'b1;
                     state     <= S_SAMPLE;
                     win_start <= 1'b1;
                  end else if (fin_len < EYE_MIN) begin
                     state    <= S_FAIL;
                     mmcm_rst <= 1'b1;
                     busy     <= 1'b0;
                     fail     <= 1'b1;
                  end else begin
                     state     <= S_CENTER;
                     eye_start <= fin_start;
                     eye_width <= fin_len;
                     target    <= POS_W'(tgt_sum);
                     pos       <= '0;
                     ps_wait   <= 1'b0;
                  end
               end else if (timer == TMO_LAST) begin
                  state    <= S_FAIL;
                  mmcm_rst <= 1'b1;
                  busy     <= 1'b0;
                  fail     <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            // The sweep wrapped the phase back to 0, so pos now counts centring steps.
            S_CENTER: begin
               if (!mmcm_locked) begin
                  state    <= S_MRST;
                  timer    <= '0;
                  mmcm_rst <= 1'b1;
               end else if (ps_wait) begin
                  if (ps_done) begin
                     ps_wait <= 1'b0;
                     pos     <= pos + 1'b1;
                  end else if (timer == TMO_LAST) begin
                     state    <= S_FAIL;
                     ps_wait  <= 1'b0;
                     mmcm_rst <= 1'b1;
                     busy     <= 1'b0;
                     fail     <= 1'b1;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end else if (pos == target) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  ps_en   <= 1'b1;
                  ps_wait <= 1'b1;
                  timer   <= '0;
               end
            end

            default: begin
               state <= S_IDLE;
               mmcm_rst <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zmod_rxdll_align.sv
// Directed bench for zmod_rxdll_align with a behavioural MMCM and lane-data model.
module tb_zmod_rxdll_align;

   localparam int          PS_RANGE = 112;
   localparam int          TMO      = 500;
   localparam logic [7:0]  PAT      = 8'hA5;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [15:0] rx_data = '0;
   logic        mmcm_locked;
   logic        ps_done = 1'b0;
   logic        mmcm_rst;
   logic        ps_en;
   logic        ps_incdec;
   logic        busy;
   logic        done;
   logic        fail;
   logic [6:0]  eye_start;
   logic [7:0]  eye_width;

   int total = 0;
   int bad   = 0;

   // Behavioural MMCM / lane model state
   int   phase = 0;
   int   ps_dly = 0;
   int   lock_dly = 0;
   logic lock_model = 1'b0;
   int   ps_en_cnt = 0;
   int   proto_err = 0;
   logic kill_lock = 1'b0;
   logic lock_block = 1'b0;
   logic hold_psdone = 1'b0;
   int   wa_lo = 0, wa_hi = -1, wb_lo = 0, wb_hi = -1, bad1 = -1;

   assign mmcm_locked = lock_model && !kill_lock;

   always #5 clk = ~clk;

   zmod_rxdll_align #(
      .NLANES       (2),
      .WORD_W       (8),
      .PATTERN      (PAT),
      .PS_RANGE     (PS_RANGE),
      .SAMPLE_CNT   (8),
      .MIN_EYE      (8),
      .RST_CYCLES   (16),
      .LOCK_TIMEOUT (TMO)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .start       (start),
      .rx_data     (rx_data),
      .mmcm_locked (mmcm_locked),
      .ps_done     (ps_done),
      .mmcm_rst    (mmcm_rst),
      .ps_en       (ps_en),
      .ps_incdec   (ps_incdec),
      .busy        (busy),
      .done        (done),
      .fail        (fail),
      .eye_start   (eye_start),
      .eye_width   (eye_width)
   );

   function automatic logic in_win(input int ph);
      return (ph >= wa_lo && ph <= wa_hi) || (ph >= wb_lo && ph <= wb_hi);
   endfunction

   always @(negedge clk) begin
      ps_done = 1'b0;
      if (mmcm_rst) begin
         lock_model = 1'b0;
         lock_dly   = 0;
         phase      = 0;
         ps_dly     = 0;
      end else begin
         if (!lock_model && !lock_block) begin
            if (lock_dly == 6) lock_model = 1'b1;
            else lock_dly = lock_dly + 1;
         end
         if (ps_en) begin
            ps_en_cnt = ps_en_cnt + 1;
            if (ps_dly != 0) proto_err = proto_err + 1;
            ps_dly = 3;
         end else if (ps_dly != 0) begin
            ps_dly = ps_dly - 1;
            if (ps_dly == 0 && !hold_psdone) begin
               ps_done = 1'b1;
               phase   = (phase + 1) % PS_RANGE;
            end
         end
      end
      rx_data[7:0]  = in_win(phase) ? PAT : ~PAT;
      rx_data[15:8] = (in_win(phase) && phase != bad1) ? PAT : ~PAT;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_end(input string tag);
      int n;
      n = 0;
      while (!(done || fail) && n < 8000) begin
         tick();
         n = n + 1;
      end
      check({tag, " finished"}, 32'(done || fail), 1);
   endtask

   task automatic train(input string tag, input int alo, input int ahi,
                        input int blo, input int bhi, input int b1);
      wa_lo = alo; wa_hi = ahi; wb_lo = blo; wb_hi = bhi; bad1 = b1;
      pulse_start();
      wait_end(tag);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " mmcm_rst"},  32'(mmcm_rst), 1);
      check({tag, " ps_en"},     32'(ps_en), 0);
      check({tag, " ps_incdec"}, 32'(ps_incdec), 1);
      check({tag, " busy"},      32'(busy), 0);
      check({tag, " done"},      32'(done), 0);
      check({tag, " fail"},      32'(fail), 0);
      check({tag, " eye_start"}, 32'(eye_start), 0);
      check({tag, " eye_width"}, 32'(eye_width), 0);
   endtask

   initial begin
      int base;
      int n;

      // Reset state
      resetn = 1'b0;
      repeat (3) tick();
      check_reset_vals("reset");
      resetn = 1'b1;
      tick();

      // Full pass window 40..71, with a start pulse ignored mid-training
      wa_lo = 40; wa_hi = 71; wb_lo = 0; wb_hi = -1; bad1 = -1;
      base = ps_en_cnt;
      pulse_start();
      check("full busy", 32'(busy), 1);
      repeat (100) tick();
      pulse_start();
      wait_end("full");
      check("full done", 32'(done), 1);
      check("full fail", 32'(fail), 0);
      check("full busy end", 32'(busy), 0);
      check("full eye_start", 32'(eye_start), 40);
      check("full eye_width", 32'(eye_width), 32);
      check("full ps_en pulses", 32'(ps_en_cnt - base), 112 + 56);
      check("full phase", 32'(phase), 56);
      check("full mmcm_rst", 32'(mmcm_rst), 0);

      // Narrow eye 10..14 fails; eye outputs keep the previous result
      train("narrow", 10, 14, 0, -1, -1);
      check("narrow fail", 32'(fail), 1);
      check("narrow done", 32'(done), 0);
      check("narrow mmcm_rst", 32'(mmcm_rst), 1);
      check("narrow eye_start held", 32'(eye_start), 40);
      check("narrow eye_width held", 32'(eye_width), 32);

      // Tie between 20..29 and 60..69: first window wins
      train("tie", 20, 29, 60, 69, -1);
      check("tie done", 32'(done), 1);
      check("tie fail cleared", 32'(fail), 0);
      check("tie eye_start", 32'(eye_start), 20);
      check("tie eye_width", 32'(eye_width), 10);
      check("tie phase", 32'(phase), 25);

      // Window open at the end of the sweep, exactly MIN_EYE wide
      train("edge", 104, 111, 0, -1, -1);
      check("edge done", 32'(done), 1);
      check("edge eye_start", 32'(eye_start), 104);
      check("edge eye_width", 32'(eye_width), 8);
      check("edge phase", 32'(phase), 108);

      // Windows at both ends do not join across position 0
      train("nowrap", 0, 5, 106, 111, -1);
      check("nowrap fail", 32'(fail), 1);
      check("nowrap done", 32'(done), 0);

      // Lane 1 errors only at 50 inside a clean lane-0 window 30..80
      train("lane1", 30, 80, 0, -1, 50);
      check("lane1 done", 32'(done), 1);
      check("lane1 eye_start", 32'(eye_start), 51);
      check("lane1 eye_width", 32'(eye_width), 30);
      check("lane1 phase", 32'(phase), 66);

      // Lock loss after done: automatic retrain to the same result
      kill_lock = 1'b1;
      tick();
      check("lockloss done cleared", 32'(done), 0);
      check("lockloss mmcm_rst", 32'(mmcm_rst), 1);
      check("lockloss busy", 32'(busy), 1);
      kill_lock = 1'b0;
      n = 1;
      while (n < 100) begin
         tick();
         if (!mmcm_rst) break;
         n = n + 1;
      end
      check("lockloss rst cycles", 32'(n), 16);
      wait_end("retrain");
      check("retrain done", 32'(done), 1);
      check("retrain eye_start", 32'(eye_start), 51);
      check("retrain eye_width", 32'(eye_width), 30);
      check("retrain phase", 32'(phase), 66);
      check("ps protocol", 32'(proto_err), 0);

      // ps_done withheld: STEP times out
      wa_lo = 40; wa_hi = 71; wb_lo = 0; wb_hi = -1; bad1 = -1;
      hold_psdone = 1'b1;
      pulse_start();
      n = 0;
      while (!ps_en && n < 300) begin
         tick();
         n = n + 1;
      end
      check("psdone first step seen", 32'(ps_en), 1);
      repeat (TMO - 20) tick();
      check("psdone before timeout fail", 32'(fail), 0);
      check("psdone before timeout busy", 32'(busy), 1);
      repeat (40) tick();
      check("psdone timeout fail", 32'(fail), 1);
      check("psdone timeout done", 32'(done), 0);
      check("psdone timeout mmcm_rst", 32'(mmcm_rst), 1);
      hold_psdone = 1'b0;

      // Lock never arrives: WLOCK times out
      lock_block = 1'b1;
      pulse_start();
      check("lock wait fail cleared", 32'(fail), 0);
      repeat (TMO - 10) tick();
      check("lock before timeout fail", 32'(fail), 0);
      repeat (60) tick();
      check("lock timeout fail", 32'(fail), 1);
      check("lock timeout busy", 32'(busy), 0);
      lock_block = 1'b0;

      // Reset during SAMPLE abandons training
      pulse_start();
      n = 0;
      while (mmcm_rst && n < 100) begin
         tick();
         n = n + 1;
      end
      repeat (30) tick();
      check("midreset busy before", 32'(busy), 1);
      resetn = 1'b0;
      tick();
      check_reset_vals("midreset");
      tick();
      check("midreset held mmcm_rst", 32'(mmcm_rst), 1);
      resetn = 1'b1;
      repeat (5) tick();
      check("midreset idle busy", 32'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
